// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU requesters and the register-file arbiter.
// master: requester side (drives valid/rd/data); slave: arbiter side.
interface regfile_wb_arbiter_if #(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5
);
    logic               alu_valid;
    logic [RADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]    alu_data;
    logic               alu_ready;

    logic               lsu_valid;
    logic [RADDR_W-1:0] lsu_rd;
    logic [XLEN-1:0]    lsu_data;
    logic               lsu_ready;

    logic               rf_reg_write;
    logic [RADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]    rf_write_data;
    logic               arb_state;

`ifdef WB_ARB_STATS_EN
    logic [31:0]        stat_alu_grants;
    logic [31:0]        stat_lsu_grants;
    logic [31:0]        stat_conflicts;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready,
        input  rf_reg_write, rf_rd, rf_write_data,
`ifdef WB_ARB_STATS_EN
        input  stat_alu_grants, stat_lsu_grants, stat_conflicts,
`endif
        input  arb_state
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready,
        output rf_reg_write, rf_rd, rf_write_data,
`ifdef WB_ARB_STATS_EN
        output stat_alu_grants, stat_lsu_grants, stat_conflicts,
`endif
        output arb_state
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU and LSU
// writeback requesters; one grant per cycle, issued to reg_file registered.
// Ports: clk, reset (async active-low), wb (slave modport: alu_*/lsu_*
// valid/ready requests, rf_reg_write/rf_rd/rf_write_data, arb_state).
// Optional WB_ARB_STATS_EN adds saturating grant/conflict counters on wb.
module regfile_wb_arbiter #(
    parameter int XLEN     = 64,
    parameter int RADDR_W  = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  wb
);
    typedef enum logic {
        PRI_LSU = 1'b0,
        PRI_ALU = 1'b1
    } state_e;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    state_e             state_q, state_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic               rf_we_q, rf_we_d;
    logic [RADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]    rf_data_q, rf_data_d;

    logic alu_gnt;
    logic lsu_gnt;
    logic same_rd;

    // Grant decode. Same-rd conflicts always go to the LSU: the load is
    // the older instruction, so the ALU write must land last.
    always_comb begin
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        same_rd = (wb.alu_rd == wb.lsu_rd);
        if (reset) begin
            unique case (1'b1)
                (wb.lsu_valid && !wb.alu_valid): lsu_gnt = 1'b1;
                (wb.alu_valid && !wb.lsu_valid): alu_gnt = 1'b1;
                (wb.alu_valid && wb.lsu_valid): begin
                    if (!same_rd && state_q == PRI_ALU)
                        alu_gnt = 1'b1;
                    else
                        lsu_gnt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Starvation tracking: count ALU-losing cycles, saturate at MAX_W,
    // and flip to ALU priority on the edge the count reaches MAX_W.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (alu_gnt) begin
            state_d    = PRI_LSU;
            wait_cnt_d = 4'd0;
        end else if (wb.alu_valid) begin
            if (wait_cnt_q < MAX_W)
                wait_cnt_d = wait_cnt_q + 4'd1;
            if (wait_cnt_d == MAX_W)
                state_d = PRI_ALU;
        end
    end

    // Registered write port; rd/data hold when idle, x0 writes suppressed.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        if (lsu_gnt) begin
            rf_we_d   = (wb.lsu_rd != '0);
            rf_rd_d   = wb.lsu_rd;
            rf_data_d = wb.lsu_data;
        end else if (alu_gnt) begin
            rf_we_d   = (wb.alu_rd != '0);
            rf_rd_d   = wb.alu_rd;
            rf_data_d = wb.alu_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PRI_LSU;
            wait_cnt_q <= 4'd0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_data_q  <= rf_data_d;
        end
    end

    assign wb.alu_ready     = alu_gnt;
    assign wb.lsu_ready     = lsu_gnt;
    assign wb.rf_reg_write  = rf_we_q;
    assign wb.rf_rd         = rf_rd_q;
    assign wb.rf_write_data = rf_data_q;
    assign wb.arb_state     = state_q;

`ifdef WB_ARB_STATS_EN
    logic [31:0] st_alu_q, st_alu_d;
    logic [31:0] st_lsu_q, st_lsu_d;
    logic [31:0] st_cfl_q, st_cfl_d;

    always_comb begin
        st_alu_d = st_alu_q;
        st_lsu_d = st_lsu_q;
        st_cfl_d = st_cfl_q;
        if (alu_gnt && st_alu_q != 32'hFFFF_FFFF)
            st_alu_d = st_alu_q + 32'd1;
        if (lsu_gnt && st_lsu_q != 32'hFFFF_FFFF)
            st_lsu_d = st_lsu_q + 32'd1;
        if (wb.alu_valid && wb.lsu_valid && st_cfl_q != 32'hFFFF_FFFF)
            st_cfl_d = st_cfl_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_alu_q <= '0;
            st_lsu_q <= '0;
            st_cfl_q <= '0;
        end else begin
            st_alu_q <= st_alu_d;
            st_lsu_q <= st_lsu_d;
            st_cfl_q <= st_cfl_d;
        end
    end

    assign wb.stat_alu_grants = st_alu_q;
    assign wb.stat_lsu_grants = st_lsu_q;
    assign wb.stat_conflicts  = st_cfl_q;
`endif
endmodule
